// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier control path: state encoding,
// default operand width and the bit positions of the c0..c6 control strobes.
package booth_pkg;

  localparam int N_DEF   = 8;
  localparam int NUM_CTL = 7;

  localparam int C0_IDX = 0;
  localparam int C1_IDX = 1;
  localparam int C2_IDX = 2;
  localparam int C3_IDX = 3;
  localparam int C4_IDX = 4;
  localparam int C5_IDX = 5;
  localparam int C6_IDX = 6;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    TEST,
    ADD,
    SUB,
    SHIFT,
    OUT_A,
    OUT_Q,
    DONE
  } state_t;

endpackage

// File: rtl/booth_iter_cnt.sv
// Iteration counter for the Booth sequencer; clr wins over inc, last flags cnt==N-1.
// Single-cycle update, no flow control.
module booth_iter_cnt
  import booth_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = $clog2(N)
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(N - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: Moore-decoded one-hot strobes, fin lands 5+2N+k cycles after bgn.
// No backpressure; bgn only sampled in IDLE. Optional abort port under BOOTH_CTRL_ABORT_EN.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = $clog2(N)
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bgn,
`ifdef BOOTH_CTRL_ABORT_EN
  input  logic abort,
`endif
  input  logic q0,
  input  logic q_m1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic fin
);

  state_t               state;
  state_t               state_n;
  logic [NUM_CTL-1:0]   ctl;
  logic                 fin_d;
  logic                 last;
  logic                 abort_hit;

`ifdef BOOTH_CTRL_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  booth_iter_cnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   ((state == LOAD_M) || abort_hit),
    .inc   ((state == SHIFT) && !last),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ctl     = '0;
    fin_d   = 1'b0;
    case (state)
      IDLE:   if (bgn) state_n = LOAD_M;
      LOAD_M: begin ctl[C0_IDX] = 1'b1; state_n = LOAD_Q; end
      LOAD_Q: begin ctl[C1_IDX] = 1'b1; state_n = TEST;   end
      TEST: begin
        case ({q0, q_m1})
          2'b10:   state_n = SUB;
          2'b01:   state_n = ADD;
          default: state_n = SHIFT;
        endcase
      end
      ADD:    begin ctl[C2_IDX] = 1'b1; state_n = SHIFT; end
      SUB:    begin ctl[C3_IDX] = 1'b1; state_n = SHIFT; end
      SHIFT:  begin ctl[C4_IDX] = 1'b1; state_n = last ? OUT_A : TEST; end
      OUT_A:  begin ctl[C5_IDX] = 1'b1; state_n = OUT_Q; end
      OUT_Q:  begin ctl[C6_IDX] = 1'b1; state_n = DONE;  end
      DONE:   begin fin_d = 1'b1;       state_n = IDLE;  end
      default: state_n = IDLE;
    endcase
    // abort only redirects the next state; current-cycle strobes stay a pure state decode
    if (abort_hit) state_n = IDLE;
  end

  assign c0  = ctl[C0_IDX];
  assign c1  = ctl[C1_IDX];
  assign c2  = ctl[C2_IDX];
  assign c3  = ctl[C3_IDX];
  assign c4  = ctl[C4_IDX];
  assign c5  = ctl[C5_IDX];
  assign c6  = ctl[C6_IDX];
  assign fin = fin_d;

endmodule
